rv32m_muldiv_unit: RTL and testbench



---
 rtl/rv32m_muldiv_unit_pkg.sv | 29 ++
 rtl/rv32m_div_iter.sv | 74 +++++++
 rtl/rv32m_muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_rv32m_muldiv_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32m_muldiv_unit_pkg.sv
// Shared RV32M definitions: decode constants, FSM state encoding and a decode helper
// used by the multiply/divide unit.
package rv32m_muldiv_unit_pkg;

  localparam logic [6:0] RV32M_FUNCT7 = 7'b0000001;

  localparam logic [2:0] RV32M_FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] RV32M_FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] RV32M_FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] RV32M_FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] RV32M_FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] RV32M_FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] RV32M_FUNCT3_REM    = 3'b110;
  localparam logic [2:0] RV32M_FUNCT3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MUL      = 3'd1,
    ST_DIV_INIT = 3'd2,
    ST_DIV_ITER = 3'd3,
    ST_DIV_FIX  = 3'd4,
    ST_DONE     = 3'd5
  } muldiv_state_t;

  function automatic logic funct3_is_signed_div(input logic [2:0] f);
    return (f == RV32M_FUNCT3_DIV) || (f == RV32M_FUNCT3_REM);
  endfunction

endpackage

// File: rtl/rv32m_div_iter.sv
// Iterative restoring divider core on unsigned operands; retires
// DIV_BITS_PER_CYCLE quotient bits per clock after a one-cycle load on i_start.
module rv32m_div_iter #(
  parameter int XLEN               = 32,
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_done,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder
);

  localparam int STEPS = XLEN / DIV_BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEPS);

  logic             r_active;
  logic [CNT_W-1:0] r_count;
  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_divisor;

  logic [XLEN:0]    w_step_rem;
  logic [XLEN-1:0]  w_step_quo;

  // The partial remainder gets one spare bit: shifting in a dividend bit can
  // briefly reach twice the divisor before the trial subtraction.
  always_comb begin
    w_step_rem = {1'b0, r_rem};
    w_step_quo = r_quo;
    for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
      w_step_rem = {w_step_rem[XLEN-1:0], w_step_quo[XLEN-1]};
      w_step_quo = {w_step_quo[XLEN-2:0], 1'b0};
      if (w_step_rem >= {1'b0, r_divisor}) begin
        w_step_rem    = w_step_rem - {1'b0, r_divisor};
        w_step_quo[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active  <= 1'b0;
      r_count   <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
    end else if (i_abort) begin
      r_active <= 1'b0;
    end else if (i_start) begin
      r_active  <= 1'b1;
      r_count   <= CNT_LOAD;
      r_quo     <= i_dividend;
      r_rem     <= '0;
      r_divisor <= i_divisor;
    end else if (r_active) begin
      r_quo   <= w_step_quo;
      r_rem   <= w_step_rem[XLEN-1:0];
      r_count <= r_count - CNT_W'(1);
      if (r_count == CNT_W'(1)) r_active <= 1'b0;
    end
  end

  // Done flags the final step, so the quotient is complete at the next edge.
  assign o_done      = r_active && (r_count == CNT_W'(1));
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/rv32m_muldiv_unit.sv
// RV32M multiply/divide execution unit: single-cycle multiplier, iterative
// divider, valid/ready request and response handshakes with flush support.
module rv32m_muldiv_unit
  import rv32m_muldiv_unit_pkg::*;
#(
  parameter int XLEN               = 32,
  parameter int DIV_BITS_PER_CYCLE = 1,
  parameter int TAG_W              = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  op_a_i,
  input  logic [XLEN-1:0]  op_b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t    r_state;
  muldiv_state_t    w_state_next;
  logic [2:0]       r_funct3;
  logic [XLEN-1:0]  r_op_a;
  logic [XLEN-1:0]  r_op_b;
  logic [XLEN-1:0]  r_result;
  logic [TAG_W-1:0] r_tag;
  logic             r_sign_a;
  logic             r_sign_b;
  logic             r_div_zero;
  logic             r_overflow;

  logic w_accept;
  logic w_req_signed;
  logic w_req_b_zero;
  logic w_req_overflow;

  assign w_accept       = req_valid_i && (r_state == ST_IDLE) && !flush_i;
  assign w_req_signed   = funct3_is_signed_div(funct3_i);
  assign w_req_b_zero   = (op_b_i == '0);
  assign w_req_overflow = w_req_signed && (op_a_i == MOST_NEG) && (op_b_i == '1);

  // Extending to 2*XLEN makes the low half of one unsigned product correct for every signedness mix.
  logic                w_mul_a_signed;
  logic                w_mul_b_signed;
  logic [2*XLEN-1:0]   w_mul_a;
  logic [2*XLEN-1:0]   w_mul_b;
  logic [2*XLEN-1:0]   w_product;
  logic [XLEN-1:0]     w_mul_result;

  assign w_mul_a_signed = (r_funct3 == RV32M_FUNCT3_MULH) || (r_funct3 == RV32M_FUNCT3_MULHSU);
  assign w_mul_b_signed = (r_funct3 == RV32M_FUNCT3_MULH);
  assign w_mul_a        = {{XLEN{w_mul_a_signed & r_op_a[XLEN-1]}}, r_op_a};
  assign w_mul_b        = {{XLEN{w_mul_b_signed & r_op_b[XLEN-1]}}, r_op_b};
  assign w_product      = w_mul_a * w_mul_b;
  assign w_mul_result   = (r_funct3 == RV32M_FUNCT3_MUL) ? w_product[XLEN-1:0]
                                                         : w_product[2*XLEN-1:XLEN];

  logic            w_div_start;
  logic            w_div_done;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic [XLEN-1:0] w_quotient;
  logic [XLEN-1:0] w_remainder;

  assign w_div_start = (r_state == ST_DIV_INIT);
  assign w_abs_a     = r_sign_a ? -r_op_a : r_op_a;
  assign w_abs_b     = r_sign_b ? -r_op_b : r_op_b;

  rv32m_div_iter #(
    .XLEN               (XLEN),
    .DIV_BITS_PER_CYCLE (DIV_BITS_PER_CYCLE)
  ) u_div_iter (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_div_start),
    .i_abort     (flush_i),
    .i_dividend  (w_abs_a),
    .i_divisor   (w_abs_b),
    .o_done      (w_div_done),
    .o_quotient  (w_quotient),
    .o_remainder (w_remainder)
  );

  logic [XLEN-1:0] w_quo_fixed;
  logic [XLEN-1:0] w_rem_fixed;
  logic [XLEN-1:0] w_div_result;

  assign w_quo_fixed = (r_sign_a ^ r_sign_b) ? -w_quotient : w_quotient;
  assign w_rem_fixed = r_sign_a ? -w_remainder : w_remainder;

  // Special cases bypass the divider and resolve here; funct3[1] selects remainder.
  always_comb begin
    if (r_div_zero)      w_div_result = r_funct3[1] ? r_op_a : '1;
    else if (r_overflow) w_div_result = r_funct3[1] ? '0 : r_op_a;
    else                 w_div_result = r_funct3[1] ? w_rem_fixed : w_quo_fixed;
  end

  always_comb begin
    w_state_next = r_state;
    if (flush_i) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (!funct3_i[2])                       w_state_next = ST_MUL;
            else if (w_req_b_zero || w_req_overflow) w_state_next = ST_DIV_FIX;
            else                                     w_state_next = ST_DIV_INIT;
          end
        end
        ST_MUL:      w_state_next = ST_DONE;
        ST_DIV_INIT: w_state_next = ST_DIV_ITER;
        ST_DIV_ITER: if (w_div_done) w_state_next = ST_DIV_FIX;
        ST_DIV_FIX:  w_state_next = ST_DONE;
        ST_DONE:     if (resp_ready_i) w_state_next = ST_IDLE;
        default:     w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_funct3   <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_tag      <= '0;
      r_result   <= '0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_div_zero <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_funct3   <= funct3_i;
        r_op_a     <= op_a_i;
        r_op_b     <= op_b_i;
        r_tag      <= tag_i;
        r_sign_a   <= w_req_signed & op_a_i[XLEN-1];
        r_sign_b   <= w_req_signed & op_b_i[XLEN-1];
        r_div_zero <= w_req_b_zero;
        r_overflow <= w_req_overflow;
      end
      if ((r_state == ST_MUL) && !flush_i)     r_result <= w_mul_result;
      if ((r_state == ST_DIV_FIX) && !flush_i) r_result <= w_div_result;
    end
  end

  assign req_ready_o  = (r_state == ST_IDLE);
  assign resp_valid_o = (r_state == ST_DONE);
  assign busy_o       = (r_state != ST_IDLE);
  assign result_o     = r_result;
  assign tag_o        = r_tag;

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Self-checking bench for rv32m_muldiv_unit: vector table, random ops against a
// reference model, plus backpressure, flush, reset and 2-bit-per-cycle sequences.
module tb_rv32m_muldiv_unit;
  import rv32m_muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        reqValid = 1'b0;
  logic        respReady = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] opA = '0;
  logic [31:0] opB = '0;
  logic [4:0]  tag = '0;
  logic        reqReady, respValid, busy;
  logic [31:0] result;
  logic [4:0]  tagOut;

  logic        flush2 = 1'b0;
  logic        req2Valid = 1'b0;
  logic        resp2Ready = 1'b0;
  logic [2:0]  funct3B = '0;
  logic [31:0] opA2 = '0;
  logic [31:0] opB2 = '0;
  logic [4:0]  tag2 = '0;
  logic        req2Ready, resp2Valid, busy2;
  logic [31:0] result2;
  logic [4:0]  tagOut2;

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] expRes;
    int          expLat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          lat;
    int          acceptCycle;
  } exp_t;

  vec_t vecs[18];
  exp_t sbQueue[$];

  rv32m_muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .req_valid_i(reqValid), .req_ready_o(reqReady),
    .funct3_i(funct3), .op_a_i(opA), .op_b_i(opB), .tag_i(tag),
    .resp_valid_o(respValid), .resp_ready_i(respReady),
    .result_o(result), .tag_o(tagOut), .busy_o(busy)
  );

  rv32m_muldiv_unit #(.XLEN(32), .DIV_BITS_PER_CYCLE(2), .TAG_W(5)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush2),
    .req_valid_i(req2Valid), .req_ready_o(req2Ready),
    .funct3_i(funct3B), .op_a_i(opA2), .op_b_i(opB2), .tag_i(tag2),
    .resp_valid_o(resp2Valid), .resp_ready_i(resp2Ready),
    .result_o(result2), .tag_o(tagOut2), .busy_o(busy2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %h, expected %h", name, actual, expected);
    end
  endtask

  // Independent reference built on native 64-bit and 32-bit signed arithmetic.
  function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    logic [63:0]     pv;
    int              sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (f3)
      3'b000: begin sp = longint'(sa) * longint'(sb); pv = sp; return pv[31:0]; end
      3'b001: begin sp = longint'(sa) * longint'(sb); pv = sp; return pv[63:32]; end
      3'b010: begin sp = longint'(sa) * longint'({32'h0, b}); pv = sp; return pv[63:32]; end
      3'b011: begin up = {32'h0, a} * {32'h0, b}; pv = up; return pv[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return sa / sb;
      end
      3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int refLatency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2] || b == 0) return 2;
    if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 2;
    return 35;
  endfunction

  task automatic applyStimulus(input vec_t v, input int hold);
    exp_t e;
    exp_t got;
    int   waitCnt;
    @(negedge clk);
    funct3 = v.f3; opA = v.a; opB = v.b; tag = v.tag; reqValid = 1'b1;
    waitCnt = 0;
    while (!reqReady && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput({v.name, "_req_ready"}, {31'b0, reqReady}, 32'd1);
    if (!reqReady) begin
      reqValid = 1'b0;
      return;
    end
    @(negedge clk);
    reqValid = 1'b0;
    e.res = v.expRes; e.tag = v.tag; e.lat = v.expLat; e.acceptCycle = cycleCnt;
    sbQueue.push_back(e);
    waitCnt = 0;
    while (!respValid && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput({v.name, "_resp_valid"}, {31'b0, respValid}, 32'd1);
    got = sbQueue.pop_front();
    if (!respValid) return;
    checkOutput({v.name, "_latency"}, 32'(cycleCnt - got.acceptCycle + 1), 32'(got.lat));
    checkOutput({v.name, "_result"}, result, got.res);
    checkOutput({v.name, "_tag"}, {27'b0, tagOut}, {27'b0, got.tag});
    for (int k = 0; k < hold; k++) begin
      checkOutput({v.name, "_hold_valid"}, {31'b0, respValid}, 32'd1);
      checkOutput({v.name, "_hold_result"}, result, got.res);
      checkOutput({v.name, "_hold_tag"}, {27'b0, tagOut}, {27'b0, got.tag});
      checkOutput({v.name, "_hold_req_ready"}, {31'b0, reqReady}, 32'd0);
      @(negedge clk);
    end
    respReady = 1'b1;
    @(negedge clk);
    respReady = 1'b0;
    if (hold > 0) begin
      checkOutput({v.name, "_after_req_ready"}, {31'b0, reqReady}, 32'd1);
      checkOutput({v.name, "_after_resp_valid"}, {31'b0, respValid}, 32'd0);
    end
  endtask

  task automatic runDut2(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expRes);
    int startCycle;
    int waitCnt;
    @(negedge clk);
    checkOutput({name, "_req_ready"}, {31'b0, req2Ready}, 32'd1);
    funct3B = f3; opA2 = a; opB2 = b; tag2 = 5'd3; req2Valid = 1'b1;
    @(negedge clk);
    req2Valid = 1'b0;
    startCycle = cycleCnt;
    waitCnt = 0;
    while (!resp2Valid && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput({name, "_resp_valid"}, {31'b0, resp2Valid}, 32'd1);
    if (!resp2Valid) return;
    checkOutput({name, "_latency"}, 32'(cycleCnt - startCycle + 1), 32'd19);
    checkOutput({name, "_result"}, result2, expRes);
    checkOutput({name, "_tag"}, {27'b0, tagOut2}, 32'd3);
    resp2Ready = 1'b1;
    @(negedge clk);
    resp2Ready = 1'b0;
  endtask

  initial begin
    vec_t v;
    logic sawValid;

    vecs[0]  = '{"mul_neg",       RV32M_FUNCT3_MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 2};
    vecs[1]  = '{"mulh_minmin",   RV32M_FUNCT3_MULH,   32'h80000000, 32'h80000000, 5'd1,  32'h40000000, 2};
    vecs[2]  = '{"mulhu_max",     RV32M_FUNCT3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 2};
    vecs[3]  = '{"mulhsu_max",    RV32M_FUNCT3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 2};
    vecs[4]  = '{"div_neg7_2",    RV32M_FUNCT3_DIV,    32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD, 35};
    vecs[5]  = '{"rem_neg7_2",    RV32M_FUNCT3_REM,    32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 35};
    vecs[6]  = '{"divu_100_7",    RV32M_FUNCT3_DIVU,   32'd100,      32'd7,        5'd7,  32'd14,       35};
    vecs[7]  = '{"remu_100_7",    RV32M_FUNCT3_REMU,   32'd100,      32'd7,        5'd8,  32'd2,        35};
    vecs[8]  = '{"divu_by0",      RV32M_FUNCT3_DIVU,   32'd100,      32'd0,        5'd9,  32'hFFFFFFFF, 2};
    vecs[9]  = '{"remu_by0",      RV32M_FUNCT3_REMU,   32'd100,      32'd0,        5'd10, 32'd100,      2};
    vecs[10] = '{"div_ovf",       RV32M_FUNCT3_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 2};
    vecs[11] = '{"rem_ovf",       RV32M_FUNCT3_REM,    32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,        2};
    vecs[12] = '{"div_neg_by0",   RV32M_FUNCT3_DIV,    32'hFFFFFF9C, 32'd0,        5'd13, 32'hFFFFFFFF, 2};
    vecs[13] = '{"rem_neg_by0",   RV32M_FUNCT3_REM,    32'hFFFFFF9C, 32'd0,        5'd14, 32'hFFFFFF9C, 2};
    vecs[14] = '{"div_7_neg2",    RV32M_FUNCT3_DIV,    32'd7,        32'hFFFFFFFE, 5'd15, 32'hFFFFFFFD, 35};
    vecs[15] = '{"rem_7_neg2",    RV32M_FUNCT3_REM,    32'd7,        32'hFFFFFFFE, 5'd16, 32'd1,        35};
    vecs[16] = '{"div_min_2",     RV32M_FUNCT3_DIV,    32'h80000000, 32'd2,        5'd17, 32'hC0000000, 35};
    vecs[17] = '{"divu_max_1",    RV32M_FUNCT3_DIVU,   32'hFFFFFFFF, 32'd1,        5'd18, 32'hFFFFFFFF, 35};

    repeat (3) @(negedge clk);
    checkOutput("reset_req_ready", {31'b0, reqReady}, 32'd1);
    checkOutput("reset_resp_valid", {31'b0, respValid}, 32'd0);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_tag", {27'b0, tagOut}, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) applyStimulus(vecs[i], 0);

    for (int i = 0; i < 10; i++) begin
      v.name = $sformatf("rand%0d", i);
      v.f3   = 3'($urandom_range(0, 7));
      v.a    = $urandom;
      case ($urandom_range(0, 3))
        0:       v.b = 32'($urandom_range(0, 15));
        1:       v.b = -32'($urandom_range(1, 15));
        default: v.b = $urandom;
      endcase
      v.tag    = 5'($urandom_range(0, 31));
      v.expRes = refModel(v.f3, v.a, v.b);
      v.expLat = refLatency(v.f3, v.a, v.b);
      applyStimulus(v, 0);
    end

    // A request arriving together with flush in IDLE must be ignored.
    @(negedge clk);
    funct3 = RV32M_FUNCT3_MUL; opA = 32'd5; opB = 32'd5; tag = 5'd1;
    reqValid = 1'b1; flush = 1'b1;
    @(negedge clk);
    reqValid = 1'b0; flush = 1'b0;
    checkOutput("idle_flush_busy", {31'b0, busy}, 32'd0);
    checkOutput("idle_flush_req_ready", {31'b0, reqReady}, 32'd1);

    v = '{"backpressure", RV32M_FUNCT3_DIVU, 32'd100, 32'd7, 5'd21, 32'd14, 35};
    applyStimulus(v, 5);

    @(negedge clk);
    funct3 = RV32M_FUNCT3_DIV; opA = 32'hFFFFFFF9; opB = 32'd2; tag = 5'd22; reqValid = 1'b1;
    @(negedge clk);
    reqValid = 1'b0;
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_req_ready", {31'b0, reqReady}, 32'd1);
    checkOutput("flush_busy", {31'b0, busy}, 32'd0);
    sawValid = respValid;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      sawValid = sawValid | respValid;
    end
    checkOutput("flush_no_resp", {31'b0, sawValid}, 32'd0);

    v = '{"mul_after_flush", RV32M_FUNCT3_MUL, 32'd3, 32'd4, 5'd23, 32'd12, 2};
    applyStimulus(v, 0);

    @(negedge clk);
    funct3 = RV32M_FUNCT3_DIVU; opA = 32'd1000; opB = 32'd3; tag = 5'd24; reqValid = 1'b1;
    @(negedge clk);
    reqValid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("async_rst_req_ready", {31'b0, reqReady}, 32'd1);
    checkOutput("async_rst_resp_valid", {31'b0, respValid}, 32'd0);
    checkOutput("async_rst_result", result, 32'd0);
    checkOutput("async_rst_tag", {27'b0, tagOut}, 32'd0);
    sbQueue.delete();
    @(negedge clk);
    rst_n = 1'b1;

    runDut2("dut2_divu", RV32M_FUNCT3_DIVU, 32'd100, 32'd7, 32'd14);
    runDut2("dut2_rem", RV32M_FUNCT3_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    runDut2("dut2_div", RV32M_FUNCT3_DIV, 32'h87654321, 32'h00001234,
            refModel(RV32M_FUNCT3_DIV, 32'h87654321, 32'h00001234));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
